// File: rtl/mux8_scan_ctrl.sv
// Serializes an 8-bit word onto an external 8:1 mux by stepping its select lines.
// Optional trailing parity slot enabled by defining MUX8_SCAN_PARITY_EN.
module mux8_scan_ctrl #(
  parameter int MSB_FIRST = 0,
  parameter int HOLD      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       ready,
  output logic       I0,
  output logic       I1,
  output logic       I2,
  output logic       I3,
  output logic       I4,
  output logic       I5,
  output logic       I6,
  output logic       I7,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       sel_valid,
  output logic       last,
  output logic       done
`ifdef MUX8_SCAN_PARITY_EN
  ,
  output logic       par_bit,
  output logic       par_valid
`endif
);

  // state | meaning
  // IDLE  | ready for load; select lines hold last index
  // SCAN  | stepping select through the eight data slots
  // PAR   | parity slot after the data (parity build only)
  typedef enum logic [1:0] {
    IDLE,
    SCAN
`ifdef MUX8_SCAN_PARITY_EN
    , PAR
`endif
  } state_t;

  localparam logic [2:0] FIRST_IDX = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0] FINAL_IDX = (MSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic       ready_d, sel_valid_d, last_d, done_d;
`ifdef MUX8_SCAN_PARITY_EN
  logic       par_bit_d, par_valid_d;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          word_d  = din;
          idx_d   = FIRST_IDX;
          hold_d  = 4'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = 4'd0;
          if (idx_q == FINAL_IDX) begin
`ifdef MUX8_SCAN_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = (MSB_FIRST != 0) ? idx_q - 3'd1 : idx_q + 3'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
`ifdef MUX8_SCAN_PARITY_EN
      PAR: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = 4'd0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    ready_d     = (state_d == IDLE);
    sel_valid_d = (state_d == SCAN);
    last_d      = sel_valid_d && (idx_d == FINAL_IDX);
`ifdef MUX8_SCAN_PARITY_EN
    par_valid_d = (state_d == PAR);
    par_bit_d   = ^word_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= 8'd0;
      idx_q     <= 3'd0;
      hold_q    <= 4'd0;
      ready     <= 1'b1;
      sel_valid <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
`ifdef MUX8_SCAN_PARITY_EN
      par_bit   <= 1'b0;
      par_valid <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      ready     <= ready_d;
      sel_valid <= sel_valid_d;
      last      <= last_d;
      done      <= done_d;
`ifdef MUX8_SCAN_PARITY_EN
      par_bit   <= par_bit_d;
      par_valid <= par_valid_d;
`endif
    end
  end

  assign {I7, I6, I5, I4, I3, I2, I1, I0} = word_q;
  assign {S2, S1, S0} = idx_q;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: three instances cover LSB/HOLD=1, MSB/HOLD=3, LSB/HOLD=2.
module tb_mux8_scan_ctrl;

  localparam int MSBS  [3] = '{0, 1, 0};
  localparam int HOLDS [3] = '{1, 3, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load [3];
  logic [7:0] din  [3];

  logic       rdy_w [3];
  logic       sv_w  [3];
  logic       last_w[3];
  logic       done_w[3];
  logic       pb_w  [3];
  logic       pv_w  [3];
  logic [7:0] i_w   [3];
  logic [2:0] s_w   [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux8_scan_ctrl #(.MSB_FIRST(MSBS[g]), .HOLD(HOLDS[g])) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .din       (din[g]),
      .ready     (rdy_w[g]),
      .I0        (i_w[g][0]),
      .I1        (i_w[g][1]),
      .I2        (i_w[g][2]),
      .I3        (i_w[g][3]),
      .I4        (i_w[g][4]),
      .I5        (i_w[g][5]),
      .I6        (i_w[g][6]),
      .I7        (i_w[g][7]),
      .S0        (s_w[g][0]),
      .S1        (s_w[g][1]),
      .S2        (s_w[g][2]),
      .sel_valid (sv_w[g]),
      .last      (last_w[g]),
      .done      (done_w[g])
`ifdef MUX8_SCAN_PARITY_EN
      ,
      .par_bit   (pb_w[g]),
      .par_valid (pv_w[g])
`endif
    );
`ifndef MUX8_SCAN_PARITY_EN
    assign pb_w[g] = 1'b0;
    assign pv_w[g] = 1'b0;
`endif
  end

  task automatic chk(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after the accept edge; returns in the done cycle.
  task automatic frame_body(input int n, input logic [7:0] word, input bit busy_load);
    logic [2:0] idx;
    logic [7:0] w;
    logic [2:0] fin;
    w   = word;
    fin = (MSBS[n] != 0) ? 3'd0 : 3'd7;
    din[n] = ~word;
    for (int s = 0; s < 8; s++) begin
      idx = (MSBS[n] != 0) ? 3'(7 - s) : 3'(s);
      for (int h = 0; h < HOLDS[n]; h++) begin
        chk("sel_valid", n, {7'd0, sv_w[n]}, 8'd1);
        chk("ready_busy", n, {7'd0, rdy_w[n]}, 8'd0);
        chk("sel", n, {5'd0, s_w[n]}, {5'd0, idx});
        chk("word", n, i_w[n], w);
        chk("mux_y", n, {7'd0, i_w[n][s_w[n]]}, {7'd0, w[idx]});
        chk("last", n, {7'd0, last_w[n]}, {7'd0, (idx == fin)});
        chk("done_busy", n, {7'd0, done_w[n]}, 8'd0);
        if (busy_load && s == 3 && h == 0) begin
          load[n] = 1'b1;
          din[n]  = 8'hFF;
        end else begin
          load[n] = 1'b0;
        end
        step();
      end
    end
    load[n] = 1'b0;
`ifdef MUX8_SCAN_PARITY_EN
    for (int h = 0; h < HOLDS[n]; h++) begin
      chk("par_valid", n, {7'd0, pv_w[n]}, 8'd1);
      chk("par_bit", n, {7'd0, pb_w[n]}, {7'd0, ^w});
      chk("sel_valid_par", n, {7'd0, sv_w[n]}, 8'd0);
      chk("done_par", n, {7'd0, done_w[n]}, 8'd0);
      step();
    end
    chk("par_valid_end", n, {7'd0, pv_w[n]}, 8'd0);
`endif
    chk("done", n, {7'd0, done_w[n]}, 8'd1);
    chk("ready_done", n, {7'd0, rdy_w[n]}, 8'd1);
    chk("sel_valid_idle", n, {7'd0, sv_w[n]}, 8'd0);
    chk("sel_kept", n, {5'd0, s_w[n]}, {5'd0, fin});
  endtask

  task automatic chk_reset(input int n);
    chk("rst_ready", n, {7'd0, rdy_w[n]}, 8'd1);
    chk("rst_sel_valid", n, {7'd0, sv_w[n]}, 8'd0);
    chk("rst_sel", n, {5'd0, s_w[n]}, 8'd0);
    chk("rst_word", n, i_w[n], 8'd0);
    chk("rst_last", n, {7'd0, last_w[n]}, 8'd0);
    chk("rst_done", n, {7'd0, done_w[n]}, 8'd0);
    chk("rst_par_valid", n, {7'd0, pv_w[n]}, 8'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      load[k] = 1'b0;
      din[k]  = 8'd0;
    end
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) chk_reset(k);
    rst = 1'b0;

    // LSB-first, HOLD=1, 8'hA5
    load[0] = 1'b1;
    din[0]  = 8'hA5;
    step();
    load[0] = 1'b0;
    frame_body(0, 8'hA5, 1'b0);

    // Back-to-back accept in the done cycle, with a busy load of 8'hFF mid-frame
    load[0] = 1'b1;
    din[0]  = 8'h01;
    step();
    load[0] = 1'b0;
    frame_body(0, 8'h01, 1'b1);
    step();
    chk("done_single", 0, {7'd0, done_w[0]}, 8'd0);
    chk("ready_after", 0, {7'd0, rdy_w[0]}, 8'd1);

    // Reset mid-frame, with load held during reset
    load[0] = 1'b1;
    din[0]  = 8'h5A;
    step();
    load[0] = 1'b0;
    step();
    step();
    rst     = 1'b1;
    load[0] = 1'b1;
    step();
    step();
    chk_reset(0);
    rst     = 1'b0;
    load[0] = 1'b0;
    step();
    chk("no_done_after_rst", 0, {7'd0, done_w[0]}, 8'd0);
    chk("idle_after_rst", 0, {7'd0, sv_w[0]}, 8'd0);

    // MSB-first, HOLD=3, 8'h3C
    load[1] = 1'b1;
    din[1]  = 8'h3C;
    step();
    load[1] = 1'b0;
    frame_body(1, 8'h3C, 1'b0);
    step();
    chk("done_single", 1, {7'd0, done_w[1]}, 8'd0);

    // LSB-first, HOLD=2, 8'h07 (odd weight: parity bit 1 when enabled)
    load[2] = 1'b1;
    din[2]  = 8'h07;
    step();
    load[2] = 1'b0;
    frame_body(2, 8'h07, 1'b0);
    step();
    chk("done_single", 2, {7'd0, done_w[2]}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
